// File: rtl/branch_predict_ctrl.sv
// rtl/branch_predict_ctrl.sv - per-PC 2-bit saturating branch predictor with in-flight prediction FIFO
module branch_predict_ctrl #(
  parameter int INDEX_BITS  = 6,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        lookupValid_i,
  input  logic [31:0] lookupPC_i,
  output logic        predictTaken_o,
  output logic        lookupAccept_o,
  input  logic        resolveValid_i,
  input  logic        resolveTaken_i,
  input  logic        flush_i,
  output logic        mispredict_o,
  output logic        ready_o,
  output logic        queueFull_o,
  output logic        queueEmpty_o,
  output logic        resolveErr_o,
  output logic [15:0] branchCount_o,
  output logic [15:0] mispredictCount_o
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int PTR_BITS = $clog2(QUEUE_DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t                  state_q, state_d;
  logic [INDEX_BITS-1:0]   init_ptr_q, init_ptr_d;
  logic [PTR_BITS-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNT_BITS-1:0]     count_q, count_d;
  logic                    resolve_err_q, resolve_err_d;
  logic [15:0]             branch_cnt_q, branch_cnt_d;
  logic [15:0]             mispred_cnt_q, mispred_cnt_d;

  // Counter table and queue payload carry no reset: INIT rewrites the table
  // and the queue payload is only read behind a non-zero count.
  logic [1:0]              table_q  [ENTRIES];
  logic [INDEX_BITS-1:0]   q_idx_q  [QUEUE_DEPTH];
  logic                    q_pred_q [QUEUE_DEPTH];

  logic [INDEX_BITS-1:0]   lookup_idx;
  logic [INDEX_BITS-1:0]   head_idx;
  logic                    head_pred;
  logic [1:0]              head_ctr, head_ctr_upd;
  logic                    ready, queue_full, queue_empty;
  logic                    accept, resolve_pop, mispred;
  logic                    unused_pc_bits;

  assign lookup_idx     = lookupPC_i[INDEX_BITS+1:2];
  assign unused_pc_bits = ^{lookupPC_i[31:INDEX_BITS+2], lookupPC_i[1:0]};

  assign queue_full  = (count_q == CNT_BITS'(QUEUE_DEPTH));
  assign queue_empty = (count_q == '0);
  assign head_idx    = q_idx_q[head_q];
  assign head_pred   = q_pred_q[head_q];
  assign head_ctr    = table_q[head_idx];

  assign predictTaken_o = ready & table_q[lookup_idx][1];
  assign resolve_pop    = resolveValid_i & ~queue_empty;
  assign mispred        = resolve_pop & (head_pred != resolveTaken_i);
  // A full queue can still take a lookup when the head retires in the same cycle.
  assign accept         = lookupValid_i & ready & (~queue_full | resolveValid_i) & ~flush_i;

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    ready      = 1'b0;
    case (state_q)
      INIT: begin
        init_ptr_d = init_ptr_q + INDEX_BITS'(1);
        if (init_ptr_q == '1) state_d = RUN;
      end
      RUN: ready = 1'b1;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    head_ctr_upd = head_ctr;
    if (resolveTaken_i) begin
      if (head_ctr != 2'b11) head_ctr_upd = head_ctr + 2'd1;
    end else begin
      if (head_ctr != 2'b00) head_ctr_upd = head_ctr - 2'd1;
    end
  end

  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    resolve_err_d = resolve_err_q | (resolveValid_i & queue_empty);
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (resolve_pop) begin
      head_d       = head_q + PTR_BITS'(1);
      branch_cnt_d = branch_cnt_q + 16'd1;
      if (mispred) mispred_cnt_d = mispred_cnt_q + 16'd1;
    end
    if (accept) tail_d = tail_q + PTR_BITS'(1);
    case ({accept, resolve_pop})
      2'b10:   count_d = count_q + CNT_BITS'(1);
      2'b01:   count_d = count_q - CNT_BITS'(1);
      default: count_d = count_q;
    endcase
    if (flush_i) begin
      head_d  = tail_q;
      count_d = '0;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q       <= INIT;
      init_ptr_q    <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      resolve_err_q <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      init_ptr_q    <= init_ptr_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      resolve_err_q <= resolve_err_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (state_q == INIT) begin
      table_q[init_ptr_q] <= 2'b01;
    end else if (resolve_pop) begin
      table_q[head_idx] <= head_ctr_upd;
    end
    if (accept) begin
      q_idx_q[tail_q]  <= lookup_idx;
      q_pred_q[tail_q] <= predictTaken_o;
    end
  end

  assign lookupAccept_o    = accept;
  assign mispredict_o      = mispred;
  assign ready_o           = ready;
  assign queueFull_o       = queue_full;
  assign queueEmpty_o      = queue_empty;
  assign resolveErr_o      = resolve_err_q;
  assign branchCount_o     = branch_cnt_q;
  assign mispredictCount_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb/tb_branch_predict_ctrl.sv - scoreboard bench for branch_predict_ctrl
module tb_branch_predict_ctrl;

  logic        Clock = 1'b0;
  logic        nReset = 1'b1;
  logic        lookupValid = 1'b0;
  logic [31:0] lookupPC = '0;
  logic        resolveValid = 1'b0;
  logic        resolveTaken = 1'b0;
  logic        flush = 1'b0;
  logic        predictTaken, lookupAccept, mispredict, ready;
  logic        queueFull, queueEmpty, resolveErr;
  logic [15:0] branchCount, mispredictCount;

  always #5 Clock = ~Clock;

  branch_predict_ctrl #(.INDEX_BITS(6), .QUEUE_DEPTH(2)) dut (
    .Clock(Clock), .nReset(nReset),
    .lookupValid_i(lookupValid), .lookupPC_i(lookupPC),
    .predictTaken_o(predictTaken), .lookupAccept_o(lookupAccept),
    .resolveValid_i(resolveValid), .resolveTaken_i(resolveTaken), .flush_i(flush),
    .mispredict_o(mispredict), .ready_o(ready),
    .queueFull_o(queueFull), .queueEmpty_o(queueEmpty), .resolveErr_o(resolveErr),
    .branchCount_o(branchCount), .mispredictCount_o(mispredictCount)
  );

  typedef struct packed {
    logic [5:0] idx;
    logic       pred;
  } sb_t;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [1:0]  m_tbl [64];
  sb_t         sb_q [$];
  logic        m_err;
  logic [15:0] m_bc, m_mc;
  int          m_cyc;
  logic        last_pred, last_acc, last_mis, last_ready;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    foreach (m_tbl[i]) m_tbl[i] = 2'b01;
    sb_q.delete();
    m_err = 1'b0;
    m_bc  = '0;
    m_mc  = '0;
    m_cyc = 0;
  endtask

  task automatic do_reset();
    nReset       = 1'b0;
    lookupValid  = 1'b1;
    lookupPC     = 32'h100;
    resolveValid = 1'b0;
    flush        = 1'b0;
    #1;
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_pred", 32'(predictTaken), 32'd0);
    check_eq("rst_accept", 32'(lookupAccept), 32'd0);
    check_eq("rst_mispredict", 32'(mispredict), 32'd0);
    check_eq("rst_empty", 32'(queueEmpty), 32'd1);
    check_eq("rst_full", 32'(queueFull), 32'd0);
    check_eq("rst_err", 32'(resolveErr), 32'd0);
    check_eq("rst_bc", 32'(branchCount), 32'd0);
    check_eq("rst_mc", 32'(mispredictCount), 32'd0);
    repeat (2) @(posedge Clock);
    #1;
    lookupValid = 1'b0;
    nReset = 1'b1;
    model_reset();
  endtask

  task automatic step(input logic lv, input logic [31:0] pc, input logic rv, input logic rt, input logic fl);
    logic       m_ready, e_pred, e_full, e_empty, e_acc, e_pop, e_mis;
    logic [5:0] idx;
    sb_t        e;
    lookupValid  = lv;
    lookupPC     = pc;
    resolveValid = rv;
    resolveTaken = rt;
    flush        = fl;
    #3;
    m_ready = (m_cyc >= 64);
    idx     = pc[7:2];
    e_pred  = m_ready & m_tbl[idx][1];
    e_full  = (sb_q.size() == 2);
    e_empty = (sb_q.size() == 0);
    e_acc   = lv & m_ready & (~e_full | rv) & ~fl;
    e_pop   = rv & ~e_empty;
    e_mis   = 1'b0;
    if (e_pop) e_mis = (sb_q[0].pred != rt);
    check_eq("ready", 32'(ready), 32'(m_ready));
    check_eq("predictTaken", 32'(predictTaken), 32'(e_pred));
    check_eq("lookupAccept", 32'(lookupAccept), 32'(e_acc));
    check_eq("mispredict", 32'(mispredict), 32'(e_mis));
    check_eq("queueFull", 32'(queueFull), 32'(e_full));
    check_eq("queueEmpty", 32'(queueEmpty), 32'(e_empty));
    last_pred  = predictTaken;
    last_acc   = lookupAccept;
    last_mis   = mispredict;
    last_ready = ready;
    if (e_pop) begin
      e = sb_q.pop_front();
      if (rt) m_tbl[e.idx] = (m_tbl[e.idx] == 2'b11) ? 2'b11 : m_tbl[e.idx] + 2'd1;
      else    m_tbl[e.idx] = (m_tbl[e.idx] == 2'b00) ? 2'b00 : m_tbl[e.idx] - 2'd1;
      m_bc = m_bc + 16'd1;
      if (e_mis) m_mc = m_mc + 16'd1;
    end
    if (rv && e_empty) m_err = 1'b1;
    if (e_acc) sb_q.push_back('{idx: idx, pred: e_pred});
    if (fl) sb_q.delete();
    @(posedge Clock);
    #1;
    m_cyc++;
    check_eq("branchCount", 32'(branchCount), 32'(m_bc));
    check_eq("mispredictCount", 32'(mispredictCount), 32'(m_mc));
    check_eq("resolveErr", 32'(resolveErr), 32'(m_err));
    check_eq("queueEmpty_post", 32'(queueEmpty), 32'(sb_q.size() == 0));
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Lookup with flush: prediction is driven but nothing is queued.
  task automatic peek(input logic [31:0] pc);
    step(1'b1, pc, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();

    for (int i = 0; i <= 64; i++) begin
      step(i < 64, {$urandom_range(0, 1023), 2'b00}, 1'b0, 1'b0, 1'b0);
      if (i == 63) check_eq("ready_cycle63", 32'(last_ready), 32'd0);
    end
    check_eq("ready_cycle64", 32'(last_ready), 32'd1);
    check_eq("pred_after_init", 32'(last_pred), 32'd0);

    step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    check_eq("pc100_second_pred", 32'(last_pred), 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    end
    peek(32'h100);
    check_eq("pc100_after_3nt", 32'(last_pred), 32'd0);
    peek(32'h104);
    check_eq("pc104_unaffected", 32'(last_pred), 32'd0);

    step(1'b1, 32'h140, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h144, 1'b0, 1'b0, 1'b0);
    check_eq("fill_full", 32'(queueFull), 32'd1);
    step(1'b1, 32'h148, 1'b0, 1'b0, 1'b0);
    check_eq("full_reject", 32'(last_acc), 32'd0);
    step(1'b1, 32'h148, 1'b1, 1'b1, 1'b0);
    check_eq("full_accept_with_resolve", 32'(last_acc), 32'd1);
    check_eq("still_full", 32'(queueFull), 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    do_reset();
    repeat (64) idle();
    step(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    check_eq("pc200_pred", 32'(last_pred), 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    check_eq("pc200_mispredict", 32'(last_mis), 32'd1);
    check_eq("pc200_bc", 32'(branchCount), 32'd1);
    check_eq("pc200_mc", 32'(mispredictCount), 32'd1);

    step(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h304, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    check_eq("flush_empty", 32'(queueEmpty), 32'd1);
    peek(32'h300);
    check_eq("flush_old_updated", 32'(last_pred), 32'd1);
    peek(32'h304);
    check_eq("flush_young_kept", 32'(last_pred), 32'd0);

    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    check_eq("err_set", 32'(resolveErr), 32'd1);
    check_eq("err_bc_unchanged", 32'(branchCount), 32'd2);
    idle();
    idle();
    check_eq("err_sticky", 32'(resolveErr), 32'd1);

    do_reset();
    repeat (30) idle();
    do_reset();
    for (int i = 0; i <= 64; i++) step(1'b0, 32'h0, i == 10, 1'b0, 1'b0);
    check_eq("ready_after_midinit_reset", 32'(last_ready), 32'd1);
    check_eq("init_resolve_err", 32'(resolveErr), 32'd1);

    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 1), {22'h0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00},
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
